// File: rtl/rgb_switch_pwm.sv
`default_nettype none
// ============================================================================
// rgb_switch_pwm : debounced slide switches gating a shared-duty PWM on RGB LED
// Revision 1.0
// ============================================================================
module rgb_switch_pwm #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int PWM_BITS        = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          SW,
   input  logic [PWM_BITS-1:0] DUTY,
   output logic                R,
   output logic                G,
   output logic                B,
   output logic [2:0]          sw_db,
   output logic [2:0]          sw_rise
);

   localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] PWM_LAST = '1;

   logic [2:0]          sync1;
   logic [2:0]          sync2;
   logic [2:0]          db_prev;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty_q;
   logic [2:0]          led;
   logic                pwm_on;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 3'b000;
         sync2 <= 3'b000;
      end else begin
         sync1 <= SW;
         sync2 <= sync1;
      end
   end

   // Any sample that agrees with the accepted level restarts the hold count.
   generate
      for (genvar i = 0; i < 3; i++) begin : g_debounce
         logic [CNT_W-1:0] cnt;
         logic             level;

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt   <= '0;
               level <= 1'b0;
            end else if (sync2[i] == level) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               level <= sync2[i];
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end

         assign sw_db[i] = level;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         db_prev <= 3'b000;
      end else begin
         db_prev <= sw_db;
      end
   end

   assign sw_rise = sw_db & ~db_prev;

   // Duty is only sampled at the period boundary so a period is never split.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt <= '0;
         duty_q  <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (pwm_cnt == PWM_LAST) begin
            duty_q <= DUTY;
         end
      end
   end

   assign pwm_on = (pwm_cnt < duty_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         led <= 3'b000;
      end else begin
         led <= sw_db & {3{pwm_on}};
      end
   end

   assign R = led[0];
   assign G = led[1];
   assign B = led[2];

endmodule
`default_nettype wire
